my8_core: RTL and testbench
===========================

# my8_core

Single-cycle 8-bit instruction-fetch/execute core for the MY8CPU program ROMs. It drives the 8-bit ROM address from its program counter and decodes the returned 16-bit instruction word. It executes at most one instruction per enabled clock, against registers A, B, C and a carry flag. It owns the game I/O: an 8-bit input port, sampled through a synchronizer, and an 8-bit registered LED output port.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- SYNC_STAGES, 2, flip-flop depth of the in_port synchronizer (≥2)
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- step_en  input  1  executes the current instruction on this edge when high; all architectural state holds when low
- rom_addr  output  8  instruction address; equals PC, combinational from the PC register
- rom_data  input  16  instruction word for rom_addr, same cycle; [15:10] opcode, [9:8] select, [7:0] imm
- in_port  input  8  asynchronous buttons/switches
- out_port  output  8  LED register, written by OUT
- halted  output  1  high once a JMP targets its own address
- carry  output  1  carry flag (debug/visibility)

## Operation
- Decode on opcode [15:10]; sel[8] chooses the destination/source register (0=A, 1=B).
- 0 ADD: reg ← reg+imm, 9-bit sum; carry ← bit 8.
- 2 AND: reg ← reg & imm; carry ← 0.
- 6 SL: A ← {A[6:0],0}; carry ← 0.
- 7 SR: A ← {0,A[7:1]}; carry ← 0.
- 8 MOV: reg ← imm; carry ← 0.
- 10 IN: reg ← synchronized in_port; carry ← 0.
- 11 OUT: out_port ← reg; carry ← 0.
- 12 JNC: PC ← imm if carry==0, else PC+1; carry ← 0.
- 13 JMP: PC ← imm; carry ← 0.
  - If imm==PC, halted ← 1.
- 14 INC C: C ← C+imm, 9-bit sum; carry ← bit 8.
- 15 SET C: C ← imm; carry ← 0.
- All other opcodes: NOP; PC+1, carry ← 0.
- JNC tests the carry produced by the immediately preceding executed instruction.
- PC increments modulo 256: 8'hFF wraps to 8'h00.
- Halt:
  - Once halted=1, the core stops executing and PC, A, B, C, carry and out_port freeze.
  - halted is cleared only by reset.
  - It is set on the same edge that the self-JMP executes.
- Unknown or X rom_data must never propagate X into PC; treat an undecodable word as NOP.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - PC=RESET_PC, A=B=C=8'h00, carry=0.
  - out_port=8'h00, halted=0, synchronizer flops=0.
- Throughput is one instruction per clk with step_en=1. The ROM is combinational, so there are no fetch stall cycles.
- Register, carry and PC results are visible the cycle after the executing edge.
- out_port changes on the edge where OUT executes.
- in_port latency: a change reaches IN after SYNC_STAGES clk edges.
  - The synchronizer runs every cycle regardless of step_en.
- step_en low while halted=0: full state hold.
  - rom_addr stays stable.
  - carry is preserved for a later JNC.
- Reset asserted mid-loop aborts immediately. Execution restarts at RESET_PC on the first enabled edge after rst_n deasserts.

## Structure
- Package my8_pkg holds:
  - Opcode localparams (OP_ADD=6'd0 … OP_SETC=6'd15).
  - Field slice constants.
  - A decoded-instruction struct type.
- Sub-module my8_in_sync handles the in_port synchronizer.
  - It is parameterized by SYNC_STAGES and WIDTH=8, with async active-low reset.
  - The core instantiates it once.
- The core is a single always_ff for architectural state plus an always_comb decode/ALU.

## Test plan
- MOV A,128; OUT A; SR A; OUT A with step_en=1 → out_port=8'h80 after edge 2, then 8'h40 after edge 4; rom_addr=4.
- B=3 via MOV B,3; ADD B,253 → B=0, carry=1.
  - A following JNC 55 falls through to PC+1.
  - Repeat with B=2 → B=8'hFF, carry=0, JNC jumps to 55.
- SET C,250; loop of INC C,1 and JNC back → exactly 6 INC executions.
  - Exits with C=0, carry=1, PC = JNC address+1.
- in_port=8'h01, then IN B at each step → B reflects the new value only from the (SYNC_STAGES+1)th edge.
- JMP 54 at address 54 → halted=1 on that edge.
  - All state is frozen for 20 further cycles with step_en=1.
  - rst_n pulse → halted=0, PC=0, out_port=0.
- step_en toggled 1/0 randomly during a 100-instruction tennis program → trace identical to the step_en=1 trace when compared per executed instruction.
- Async reset asserted between edges → outputs reach reset values immediately.

Source files
------------

// File: rtl/my8_pkg.sv
// Shared opcode map, instruction field positions and decoded-word type for the MY8 core.
// Decode is purely combinational: one ROM word in, one decoded struct out.
package my8_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_SL   = 6'd6;
  localparam logic [5:0] OP_SR   = 6'd7;
  localparam logic [5:0] OP_MOV  = 6'd8;
  localparam logic [5:0] OP_IN   = 6'd10;
  localparam logic [5:0] OP_OUT  = 6'd11;
  localparam logic [5:0] OP_JNC  = 6'd12;
  localparam logic [5:0] OP_JMP  = 6'd13;
  localparam logic [5:0] OP_INCC = 6'd14;
  localparam logic [5:0] OP_SETC = 6'd15;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 10;
  localparam int SEL_BIT = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [5:0] opc;
    logic       sel;
    logic [7:0] imm;
  } instr_t;

  function automatic instr_t decode(input logic [15:0] w);
    instr_t d;
    d.opc = w[OPC_MSB:OPC_LSB];
    d.sel = w[SEL_BIT];
    d.imm = w[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/my8_if.sv
// Program ROM bus: the core drives the address, the ROM returns the word in the same cycle.
// No flow control; the ROM is combinational and always ready.
interface my8_if;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/my8_in_sync.sv
// Multi-flop synchronizer for the asynchronous game input port.
// Latency SYNC_STAGES clk edges; free-running, never stalls.
module my8_in_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg <= {stg[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = stg[SYNC_STAGES-1];

endmodule

// File: rtl/my8_core.sv
// Single-cycle MY8 fetch/execute core: one instruction per edge with step_en high.
// step_en low or halted freezes all architectural state; the input synchronizer keeps running.
module my8_core
  import my8_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_en,
  my8_if.master      rom,
  input  logic [7:0] in_port,
  output logic [7:0] out_port,
  output logic       halted,
  output logic       carry
);

  logic [7:0] pc_q, a_q, b_q, c_q, out_q;
  logic       carry_q, halt_q;

  logic [7:0] pc_d, a_d, b_d, c_d, out_d;
  logic       carry_d, halt_d;

  logic [7:0] in_sync;
  logic [7:0] src, res;
  logic [8:0] sum9;
  logic       wr_reg;
  instr_t     ins;
  logic       sel_hi_unused;

  my8_in_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (8)
  ) u_in_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (in_port),
    .dout  (in_sync)
  );

  // Only the low select bit names a register; the upper one is reserved.
  assign sel_hi_unused = rom.rom_data[9];

  always_comb begin
    ins     = decode(rom.rom_data);
    src     = ins.sel ? b_q : a_q;
    res     = src;
    wr_reg  = 1'b0;
    sum9    = '0;
    pc_d    = pc_q + 8'd1;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    out_d   = out_q;
    carry_d = 1'b0;
    halt_d  = halt_q;

    // Unlisted or unknown opcodes take the default arm and behave as NOP.
    case (ins.opc)
      OP_ADD: begin
        sum9    = {1'b0, src} + {1'b0, ins.imm};
        res     = sum9[7:0];
        carry_d = sum9[8];
        wr_reg  = 1'b1;
      end
      OP_AND: begin
        res    = src & ins.imm;
        wr_reg = 1'b1;
      end
      OP_SL:  a_d = {a_q[6:0], 1'b0};
      OP_SR:  a_d = {1'b0, a_q[7:1]};
      OP_MOV: begin
        res    = ins.imm;
        wr_reg = 1'b1;
      end
      OP_IN: begin
        res    = in_sync;
        wr_reg = 1'b1;
      end
      OP_OUT: out_d = src;
      OP_JNC: begin
        if (!carry_q) pc_d = ins.imm;
      end
      OP_JMP: begin
        pc_d = ins.imm;
        if (ins.imm == pc_q) halt_d = 1'b1;
      end
      OP_INCC: begin
        sum9    = {1'b0, c_q} + {1'b0, ins.imm};
        c_d     = sum9[7:0];
        carry_d = sum9[8];
      end
      OP_SETC: c_d = ins.imm;
      default: ;
    endcase

    if (wr_reg) begin
      if (ins.sel) b_d = res;
      else         a_d = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      c_q     <= 8'h00;
      out_q   <= 8'h00;
      carry_q <= 1'b0;
      halt_q  <= 1'b0;
    end else if (step_en && !halt_q) begin
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      halt_q  <= halt_d;
    end
  end

  assign rom.rom_addr = pc_q;
  assign out_port     = out_q;
  assign halted       = halt_q;
  assign carry        = carry_q;

endmodule

// File: tb/tb_my8_core.sv
// Randomized and directed bench for my8_core against an instruction-level reference model.
module tb_my8_core;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_en = 1'b0;
  logic [7:0] in_port = 8'h00;
  logic [7:0] out_port;
  logic       halted;
  logic       carry;

  logic [15:0] rom [256];

  my8_if rom_if ();
  assign rom_if.rom_data = rom[rom_if.rom_addr];

  my8_core #(.RESET_PC(8'h00), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_en  (step_en),
    .rom      (rom_if),
    .in_port  (in_port),
    .out_port (out_port),
    .halted   (halted),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pc, m_a, m_b, m_c, m_out;
  logic       m_cy, m_halt;
  logic [7:0] hist [SYNC];

  logic [17:0] trace1 [100];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [5:0] op, input logic s, input logic [7:0] imm);
    return {op, 1'b0, s, imm};
  endfunction

  task automatic model_reset();
    m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00; m_c = 8'h00;
    m_out = 8'h00; m_cy = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < SYNC; i++) hist[i] = 8'h00;
  endtask

  // One instruction, straight from the ISA rules; the input port value seen
  // by IN is the one applied SYNC edges earlier.
  task automatic model_exec(input logic [15:0] w, input logic en, input logic [7:0] pin);
    int         sum;
    logic [7:0] r, npc, imm;
    logic       s, ncy, wr;
    if (en && !m_halt) begin
      imm = w[7:0];
      s   = w[8];
      r   = s ? m_b : m_a;
      npc = m_pc + 8'd1;
      ncy = 1'b0;
      wr  = 1'b0;
      case (w[15:10])
        6'd0: begin
          sum = int'(r) + int'(imm);
          r = 8'(sum % 256); ncy = (sum > 255); wr = 1'b1;
        end
        6'd2:  begin r = r & imm; wr = 1'b1; end
        6'd6:  m_a = 8'((int'(m_a) * 2) % 256);
        6'd7:  m_a = 8'(int'(m_a) / 2);
        6'd8:  begin r = imm; wr = 1'b1; end
        6'd10: begin r = hist[SYNC-1]; wr = 1'b1; end
        6'd11: m_out = r;
        6'd12: if (m_cy == 1'b0) npc = imm;
        6'd13: begin
          if (imm == m_pc) m_halt = 1'b1;
          npc = imm;
        end
        6'd14: begin
          sum = int'(m_c) + int'(imm);
          m_c = 8'(sum % 256); ncy = (sum > 255);
        end
        6'd15: m_c = imm;
        default: ;
      endcase
      if (wr) begin
        if (s) m_b = r;
        else   m_a = r;
      end
      m_pc = npc;
      m_cy = ncy;
    end
    for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pin;
  endtask

  task automatic tick();
    model_exec(rom[m_pc], step_en, in_port);
    @(posedge clk);
    #1;
    chk("pc", 32'(rom_if.rom_addr), 32'(m_pc));
    chk("carry", 32'(carry), 32'(m_cy));
    chk("out", 32'(out_port), 32'(m_out));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  // Asserted between edges; outputs must reach reset values without a clock.
  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", 32'(rom_if.rom_addr), 32'h00);
    chk("rst_out", 32'(out_port), 32'h00);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_carry", 32'(carry), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = ins(6'd3, 1'b0, 8'h00);
  endtask

  initial begin
    int n_inc;
    int n;
    logic last_inc_cy;
    logic [5:0] ops [12];

    ops = '{6'd0, 6'd2, 6'd6, 6'd7, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd3};
    rom_clear();
    model_reset();
    #2;
    apply_reset();
    step_en = 1'b1;

    // Shift right through A and out to the LEDs.
    rom[0] = ins(6'd8, 1'b0, 8'd128);
    rom[1] = ins(6'd11, 1'b0, 8'd0);
    rom[2] = ins(6'd7, 1'b0, 8'd0);
    rom[3] = ins(6'd11, 1'b0, 8'd0);
    tick(); tick();
    chk("sr_out1", 32'(out_port), 32'h80);
    tick(); tick();
    chk("sr_out2", 32'(out_port), 32'h40);
    chk("sr_pc", 32'(rom_if.rom_addr), 32'h04);

    // ADD carry into JNC, both fall-through and taken.
    rom_clear();
    apply_reset();
    rom[0]  = ins(6'd8, 1'b0, 8'h11);
    rom[1]  = ins(6'd11, 1'b0, 8'd0);
    rom[2]  = ins(6'd8, 1'b1, 8'd3);
    rom[3]  = ins(6'd0, 1'b1, 8'd253);
    rom[4]  = ins(6'd12, 1'b0, 8'd55);
    rom[5]  = ins(6'd11, 1'b1, 8'd0);
    rom[6]  = ins(6'd8, 1'b1, 8'd2);
    rom[7]  = ins(6'd0, 1'b1, 8'd253);
    rom[8]  = ins(6'd12, 1'b0, 8'd55);
    rom[55] = ins(6'd11, 1'b1, 8'd0);
    tick(); tick();
    chk("add_out_a", 32'(out_port), 32'h11);
    tick(); tick();
    chk("add_carry1", 32'(carry), 32'h1);
    tick();
    chk("jnc_fall", 32'(rom_if.rom_addr), 32'd5);
    tick();
    chk("add_b0", 32'(out_port), 32'h00);
    tick(); tick();
    chk("add_carry0", 32'(carry), 32'h0);
    tick();
    chk("jnc_taken", 32'(rom_if.rom_addr), 32'd55);
    tick();
    chk("add_bff", 32'(out_port), 32'hFF);

    // INC C loop counted until the carry-out exits it.
    rom_clear();
    apply_reset();
    rom[0] = ins(6'd15, 1'b0, 8'd250);
    rom[1] = ins(6'd14, 1'b0, 8'd1);
    rom[2] = ins(6'd12, 1'b0, 8'd1);
    rom[3] = ins(6'd14, 1'b0, 8'd255);
    rom[4] = ins(6'd14, 1'b0, 8'd1);
    tick();
    n_inc = 0;
    last_inc_cy = 1'b0;
    for (int k = 0; k < 40 && rom_if.rom_addr != 8'd3; k++) begin
      if (rom_if.rom_addr == 8'd1) begin
        n_inc++;
        tick();
        last_inc_cy = carry;
      end else begin
        tick();
      end
    end
    chk("incc_count", 32'(n_inc), 32'd6);
    chk("incc_last_cy", 32'(last_inc_cy), 32'h1);
    chk("incc_exit_pc", 32'(rom_if.rom_addr), 32'd3);
    tick();
    chk("incc_c255_cy", 32'(carry), 32'h0);
    tick();
    chk("incc_c0_cy", 32'(carry), 32'h1);

    // Input port latency through the synchronizer.
    rom_clear();
    in_port = 8'h00;
    apply_reset();
    in_port = 8'h01;
    rom[0] = ins(6'd10, 1'b1, 8'd0);
    rom[1] = ins(6'd10, 1'b1, 8'd0);
    rom[2] = ins(6'd10, 1'b0, 8'd0);
    rom[3] = ins(6'd11, 1'b1, 8'd0);
    rom[4] = ins(6'd11, 1'b0, 8'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("in_early", 32'(out_port), 32'h00);
    tick();
    chk("in_late", 32'(out_port), 32'h01);

    // An unknown ROM word must behave as NOP.
    rom_clear();
    apply_reset();
    rom[0] = 16'hxxxx;
    rom[1] = ins(6'd8, 1'b0, 8'd7);
    rom[2] = ins(6'd11, 1'b0, 8'd0);
    tick();
    chk("x_nop_pc", 32'(rom_if.rom_addr), 32'd1);
    tick(); tick();
    chk("x_out", 32'(out_port), 32'h07);

    // Self-jump halts; nothing moves afterwards even if the ROM changes.
    rom_clear();
    apply_reset();
    rom[0]  = ins(6'd8, 1'b0, 8'h5A);
    rom[1]  = ins(6'd11, 1'b0, 8'd0);
    rom[2]  = ins(6'd13, 1'b0, 8'd54);
    rom[54] = ins(6'd13, 1'b0, 8'd54);
    tick(); tick(); tick();
    chk("halt_not_yet", 32'(halted), 32'h0);
    tick();
    chk("halt_set", 32'(halted), 32'h1);
    rom[54] = ins(6'd0, 1'b0, 8'hFF);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("halt_hold_pc", 32'(rom_if.rom_addr), 32'd54);
      chk("halt_hold_out", 32'(out_port), 32'h5A);
    end
    apply_reset();
    chk("post_halt", 32'(halted), 32'h0);

    // Random program: reference trace with step_en=1, then replay with random stalls.
    for (int i = 0; i < 256; i++) begin
      logic [5:0] op;
      logic [7:0] imm;
      op  = ops[$urandom_range(0, 11)];
      imm = 8'($urandom_range(0, 255));
      if ((op == 6'd12 || op == 6'd13) && imm == 8'(i)) imm = imm + 8'd1;
      rom[i] = ins(op, 1'($urandom_range(0, 1)), imm);
    end
    in_port = 8'($urandom_range(0, 255));
    apply_reset();
    step_en = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    step_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      trace1[k] = {rom_if.rom_addr, out_port, carry, halted};
    end
    apply_reset();
    step_en = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n = 0;
    for (int k = 0; k < 1000 && n < 100; k++) begin
      step_en = 1'($urandom_range(0, 1));
      tick();
      if (step_en) begin
        chk("trace", 32'({rom_if.rom_addr, out_port, carry, halted}), 32'(trace1[n]));
        n++;
      end
    end
    chk("trace_len", 32'(n), 32'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
